frix_rst_seq: RTL and testbench
===============================

# frix_rst_seq

Parametrised reset sequencer and heartbeat generator for Frix board tops. It sits between the clock generator and the SoC, and produces CHANNELS independent active-low reset domains (memory controller, peripherals, CPU core, and so on). Reset assertion is asynchronous. Reset release is synchronous, gated on PLL lock, held for a programmable time and staggered per channel. The block also gives each channel a soft-reset request path and drives an optional status heartbeat.

## Interface
Parameters:
- CHANNELS, default 3: number of reset domains; channel 0 is released first.
- SYNC_STAGES, default 2: synchroniser depth for reset release and PLL_LOCKED; minimum 2.
- HOLD_CYCLES, default 1024: cycles all channels stay in reset after lock is seen; minimum 1.
- STAGE_GAP, default 16: cycles between consecutive channel releases; minimum 1.
- SOFT_HOLD, default 64: cycles a channel stays in reset after its SOFT_REQ drops.
- HB_WIDTH, default 26: heartbeat counter width.

Ports:
- CLK  in  1  system clock.
- RST_X  in  1  reset, asynchronous, active-low.
- PLL_LOCKED  in  1  asynchronous lock indication from the clock generator.
- SOFT_REQ  in  CHANNELS  per-channel soft-reset request, level, CLK domain.
- RST_X_OUT  out  CHANNELS  per-channel reset, active-low.
- READY  out  1  high when every channel is out of reset and the FSM is in RUN.
- STATE  out  2  current FSM state.
- HEARTBEAT  out  1  status LED drive.

## Operation
- Internal reset: RST_X is passed through a SYNC_STAGES flop chain, with asynchronous assert and synchronous release. The lock signal goes through its own SYNC_STAGES chain, and that chain is reset by the internal reset.
- Reset values: RST_X_OUT all 0, READY 0, STATE WAIT_LOCK (0), HEARTBEAT 0, all counters 0.
- FSM states:
  - WAIT_LOCK (0): all channels held in reset. Moves to HOLD on the first edge where synced lock is 1.
  - HOLD (1): counts exactly HOLD_CYCLES cycles, then moves to RELEASE.
  - RELEASE (2): a stage counter starts at 0 and increments every cycle. On the edge where the counter equals i*STAGE_GAP, RST_X_OUT[i] goes to 1 and stays there. On the edge after channel CHANNELS-1 is released, the FSM moves to RUN.
  - RUN (3): READY is 1, registered, and is set on the RUN-entry edge.
- Lock loss: synced lock at 0 in HOLD, RELEASE or RUN returns the FSM to WAIT_LOCK on the next edge. On that same edge all RST_X_OUT go to 0, READY goes to 0, and all counters clear.
- Soft reset:
  - Honoured only in RUN; ignored in every other state because the channels are already held in reset.
  - SOFT_REQ[i]=1 forces RST_X_OUT[i]=0 on the next edge and loads the channel's counter with SOFT_HOLD.
  - After SOFT_REQ[i] drops, the counter decrements once per cycle. RST_X_OUT[i] returns to 1 on the edge where the counter reaches 0.
  - A request that re-asserts during the countdown reloads the counter.
  - READY is 0 while any channel is in soft reset.
  - Channels are independent; soft reset of one channel does not cascade to any other.
- Simultaneous events: lock loss takes priority over soft reset. Multiple soft requests in the same cycle are all served in parallel.
- Counter widths are $clog2 of each maximum plus 1, and no counter wraps. The heartbeat counter is the only counter that wraps modulo 2^HB_WIDTH.

## Timing
- RST_X falling edge: RST_X_OUT, READY and STATE reach their reset values combinationally, with no clock needed.
- RST_X rising edge, with PLL_LOCKED stable at 1: the internal reset releases after SYNC_STAGES edges. Synced lock then becomes 1 SYNC_STAGES edges later. HOLD is entered on the following edge, called T.
- Release timeline: RST_X_OUT[i] rises at T + HOLD_CYCLES + 1 + i*STAGE_GAP. READY rises one edge after the last channel is released.
- Soft reset: assertion takes 1 cycle. Release takes SOFT_HOLD + 1 edges after the last cycle in which SOFT_REQ[i] was 1.
- PLL_LOCKED deassertion: outputs assert SYNC_STAGES + 1 edges after the deassertion.

## Configuration
- FRIX_RST_HEARTBEAT_EN defined: an HB_WIDTH counter runs while READY is 1 and holds at 0 otherwise. HEARTBEAT is the counter's MSB, registered.
- Macro not defined: the counter is absent and HEARTBEAT is tied to 0.

## Structure
- Package frix_rst_pkg holds the state encodings ST_WAIT_LOCK=2'd0, ST_HOLD=2'd1, ST_RELEASE=2'd2, ST_RUN=2'd3 and the STATE width constant.
- Sub-module frix_sync_ff is an N-stage synchroniser with asynchronous active-low reset and a configurable reset value. It is instantiated twice: once for reset release, once for PLL_LOCKED.
- The per-channel soft counters are built with a generate loop in the top module.

## Test plan
All scenarios use CHANNELS=3, SYNC_STAGES=2, HOLD_CYCLES=8, STAGE_GAP=4, SOFT_HOLD=5, with the heartbeat macro defined.
- Power-up with lock high: RST_X rises at edge 0 → HOLD at T=edge 4; RST_X_OUT rises in order 001, 011, 111 at edges 13, 17 and 21; READY is 1 at edge 22.
- Lock loss in RELEASE: PLL_LOCKED drops at edge 15 → at edge 18 all RST_X_OUT=000, READY=0 and STATE=0; the full sequence repeats after lock returns.
- Soft reset on channel 1: SOFT_REQ=3'b010 for 3 cycles in RUN → RST_X_OUT[1]=0 one edge after the rise; it returns to 1 six edges after SOFT_REQ falls; channels 0 and 2 stay at 1; READY is 0 throughout.
- Soft re-trigger: SOFT_REQ[2] pulses again 3 cycles into its countdown → the countdown restarts, and release comes 6 edges after the second pulse ends.
- Asynchronous reset mid-RUN: RST_X falls between clock edges → RST_X_OUT=000 and READY=0 before the next edge; HEARTBEAT=0.
- Heartbeat: with HB_WIDTH forced to 4 in RUN, HEARTBEAT toggles every 8 cycles; with the macro undefined, HEARTBEAT stays at 0.

Source files
------------

// File: rtl/frix_rst_pkg.sv
// Shared definitions for the Frix reset sequencer: FSM state encoding,
// state width and the counter-width helper.
package frix_rst_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  // Width that holds max_val with one spare bit, so counters never wrap.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/frix_sync_ff.sv
// N-stage synchroniser with asynchronous active-low reset and a
// configurable reset value.
module frix_sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= {STAGES{RESET_VAL}};
    else          sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/frix_rst_seq.sv
// Reset sequencer: lock-gated, staggered per-channel reset release with
// soft-reset countdowns. Heartbeat enabled by FRIX_RST_HEARTBEAT_EN.
module frix_rst_seq
  import frix_rst_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int SOFT_HOLD   = 64,
  parameter int HB_WIDTH    = 26
) (
  input  logic                CLK,
  input  logic                RST_X,
  input  logic                PLL_LOCKED,
  input  logic [CHANNELS-1:0] SOFT_REQ,
  output logic [CHANNELS-1:0] RST_X_OUT,
  output logic                READY,
  output logic [STATE_W-1:0]  STATE,
  output logic                HEARTBEAT
);

  localparam int STAGE_MAX = (CHANNELS - 1) * STAGE_GAP;
  localparam int HOLD_W    = cnt_width(HOLD_CYCLES);
  localparam int STAGE_W   = cnt_width(STAGE_MAX + 1);
  localparam int SOFT_W    = cnt_width(SOFT_HOLD);

  if (SYNC_STAGES < 2 || HOLD_CYCLES < 1 || STAGE_GAP < 1 || HB_WIDTH < 1) begin : g_bad_param
    $error("frix_rst_seq: parameter out of range");
  end

  logic rst_int_n;
  logic lock_s;

  frix_sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_rst_sync (
    .clk_i(CLK), .rst_n_i(RST_X), .d_i(1'b1), .q_o(rst_int_n)
  );

  frix_sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_lock_sync (
    .clk_i(CLK), .rst_n_i(rst_int_n), .d_i(PLL_LOCKED), .q_o(lock_s)
  );

  state_e               state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [STAGE_W-1:0]   stage_cnt_q, stage_cnt_d;
  logic [CHANNELS-1:0]  rst_out_q, rst_out_d, rel_d, soft_act_d;
  logic                 ready_q, ready_d;
  logic                 run_ok;

  // NOTE: every variable gets a default before the case so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = '0;
    stage_cnt_d = '0;
    rel_d       = rst_out_q;
    if (state_q != ST_WAIT_LOCK && !lock_s) begin
      state_d = ST_WAIT_LOCK;
      rel_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          rel_d = '0;
          if (lock_s) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          rel_d = '0;
          if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) state_d = ST_RELEASE;
          else                                        hold_cnt_d = hold_cnt_q + 1'b1;
        end
        ST_RELEASE: begin
          if (&rst_out_q) begin
            state_d = ST_RUN;
          end else begin
            for (int i = 0; i < CHANNELS; i++)
              if (stage_cnt_q == STAGE_W'(i * STAGE_GAP)) rel_d[i] = 1'b1;
            stage_cnt_d = (stage_cnt_q == STAGE_W'(STAGE_MAX)) ? stage_cnt_q
                                                               : stage_cnt_q + 1'b1;
          end
        end
        ST_RUN:  rel_d = '1;
        default: state_d = ST_WAIT_LOCK;
      endcase
    end
  end

  // Soft requests only act once the FSM is settled in RUN with lock held.
  assign run_ok = (state_q == ST_RUN) && lock_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_soft
    logic              act_q, act_d;
    logic [SOFT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      act_d = act_q;
      cnt_d = cnt_q;
      if (!run_ok) begin
        act_d = 1'b0;
        cnt_d = '0;
      end else if (SOFT_REQ[i]) begin
        act_d = 1'b1;
        cnt_d = SOFT_W'(SOFT_HOLD);
      end else if (act_q) begin
        if (cnt_q == '0) act_d = 1'b0;
        else             cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge CLK or negedge rst_int_n) begin
      if (!rst_int_n) begin
        act_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        act_q <= act_d;
        cnt_q <= cnt_d;
      end
    end

    assign soft_act_d[i] = act_d;
  end

  assign rst_out_d = rel_d & ~soft_act_d;
  assign ready_d   = (state_d == ST_RUN) && (&rst_out_d);

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_WAIT_LOCK;
      hold_cnt_q  <= '0;
      stage_cnt_q <= '0;
      rst_out_q   <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stage_cnt_q <= stage_cnt_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
    end
  end

`ifdef FRIX_RST_HEARTBEAT_EN
  logic [HB_WIDTH-1:0] hb_cnt_q;
  logic                hb_q;

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= ready_q ? hb_cnt_q + 1'b1 : '0;
      hb_q     <= hb_cnt_q[HB_WIDTH-1];
    end
  end

  assign HEARTBEAT = hb_q;
`else
  assign HEARTBEAT = 1'b0;
`endif

  assign RST_X_OUT = rst_out_q;
  assign READY     = ready_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_frix_rst_seq.sv
// Directed scoreboard bench for frix_rst_seq: power-up, lock loss,
// soft reset and re-trigger, heartbeat and asynchronous reset.
module tb_frix_rst_seq;

  logic       CLK = 1'b0;
  logic       RST_X;
  logic       PLL_LOCKED;
  logic [2:0] SOFT_REQ;
  logic [2:0] RST_X_OUT;
  logic       READY;
  logic [1:0] STATE;
  logic       HEARTBEAT;

`ifdef FRIX_RST_HEARTBEAT_EN
  localparam logic HB_ON = 1'b1;
`else
  localparam logic HB_ON = 1'b0;
`endif

  frix_rst_seq #(
    .CHANNELS(3), .SYNC_STAGES(2), .HOLD_CYCLES(8),
    .STAGE_GAP(4), .SOFT_HOLD(5), .HB_WIDTH(4)
  ) dut (
    .CLK(CLK), .RST_X(RST_X), .PLL_LOCKED(PLL_LOCKED), .SOFT_REQ(SOFT_REQ),
    .RST_X_OUT(RST_X_OUT), .READY(READY), .STATE(STATE), .HEARTBEAT(HEARTBEAT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         edge_no;
    string      tag;
    logic [2:0] rst;
    logic       rdy;
    logic [1:0] st;
    logic       hb;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   ecnt     = 0;
  int   base     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int e(input int k);
    return base + 1 + k;
  endfunction

  task automatic push(input int k, input logic [2:0] rst, input logic rdy,
                      input logic [1:0] st, input logic hb);
    exp_t x;
    x.edge_no = e(k);
    x.tag     = $sformatf("edge%0d", k);
    x.rst     = rst;
    x.rdy     = rdy;
    x.st      = st;
    x.hb      = hb;
    sb.push_back(x);
  endtask

  // One clock edge, then compare every expectation due at this edge.
  task automatic tick();
    @(posedge CLK);
    ecnt++;
    #1;
    while (sb.size() > 0 && sb[0].edge_no <= ecnt) begin
      exp_t x;
      x = sb.pop_front();
      if (x.edge_no < ecnt) begin
        check({x.tag, "_late"}, ecnt, x.edge_no);
      end else begin
        check({x.tag, "_rst_out"}, 32'(RST_X_OUT), 32'(x.rst));
        check({x.tag, "_ready"},   32'(READY),     32'(x.rdy));
        check({x.tag, "_state"},   32'(STATE),     32'(x.st));
        check({x.tag, "_hb"},      32'(HEARTBEAT), 32'(x.hb));
      end
    end
  endtask

  task automatic run_to(input int k);
    while (ecnt < e(k)) tick();
  endtask

  task automatic check_reset_now(input string tag);
    check({tag, "_rst_out"}, 32'(RST_X_OUT), 32'd0);
    check({tag, "_ready"},   32'(READY),     32'd0);
    check({tag, "_state"},   32'(STATE),     32'd0);
    check({tag, "_hb"},      32'(HEARTBEAT), 32'd0);
  endtask

  initial begin
    RST_X      = 1'b0;
    PLL_LOCKED = 1'b1;
    SOFT_REQ   = 3'b000;
    repeat (3) tick();
    check_reset_now("por");

    // Power-up with lock already high: edge 0 is the first edge seeing RST_X=1.
    RST_X = 1'b1;
    base  = ecnt;
    push( 3, 3'b000, 1'b0, 2'd0, 1'b0);
    push( 4, 3'b000, 1'b0, 2'd1, 1'b0);
    push(12, 3'b000, 1'b0, 2'd2, 1'b0);
    push(13, 3'b001, 1'b0, 2'd2, 1'b0);
    push(16, 3'b001, 1'b0, 2'd2, 1'b0);
    push(17, 3'b011, 1'b0, 2'd2, 1'b0);
    push(20, 3'b011, 1'b0, 2'd2, 1'b0);
    push(21, 3'b111, 1'b0, 2'd2, 1'b0);
    push(22, 3'b111, 1'b1, 2'd3, 1'b0);
    run_to(22);

    // Asynchronous reset from RUN, between edges.
    #2 RST_X = 1'b0;
    #1 check_reset_now("async1");
    tick();
    tick();

    // Second power-up: lock lost in RELEASE, then restored; soft resets in RUN.
    RST_X = 1'b1;
    base  = ecnt;
    push( 0, 3'b000, 1'b0, 2'd0, 1'b0);
    push( 4, 3'b000, 1'b0, 2'd1, 1'b0);
    push(12, 3'b000, 1'b0, 2'd2, 1'b0);
    push(13, 3'b001, 1'b0, 2'd2, 1'b0);
    push(15, 3'b001, 1'b0, 2'd2, 1'b0);
    push(17, 3'b011, 1'b0, 2'd2, 1'b0);
    push(18, 3'b000, 1'b0, 2'd0, 1'b0);
    push(22, 3'b000, 1'b0, 2'd0, 1'b0);
    push(23, 3'b000, 1'b0, 2'd1, 1'b0);
    push(31, 3'b000, 1'b0, 2'd2, 1'b0);
    push(32, 3'b001, 1'b0, 2'd2, 1'b0);
    push(36, 3'b011, 1'b0, 2'd2, 1'b0);
    push(40, 3'b111, 1'b0, 2'd2, 1'b0);
    push(41, 3'b111, 1'b1, 2'd3, 1'b0);
    push(44, 3'b101, 1'b0, 2'd3, 1'b0);
    push(46, 3'b101, 1'b0, 2'd3, 1'b0);
    push(51, 3'b101, 1'b0, 2'd3, 1'b0);
    push(52, 3'b111, 1'b1, 2'd3, 1'b0);
    push(55, 3'b011, 1'b0, 2'd3, 1'b0);
    push(58, 3'b011, 1'b0, 2'd3, 1'b0);
    push(60, 3'b011, 1'b0, 2'd3, 1'b0);
    push(64, 3'b011, 1'b0, 2'd3, 1'b0);
    push(65, 3'b111, 1'b1, 2'd3, 1'b0);
    push(73, 3'b111, 1'b1, 2'd3, 1'b0);
    push(74, 3'b111, 1'b1, 2'd3, HB_ON);
    push(81, 3'b111, 1'b1, 2'd3, HB_ON);
    push(82, 3'b111, 1'b1, 2'd3, 1'b0);

    run_to(15); PLL_LOCKED = 1'b0;
    run_to(20); PLL_LOCKED = 1'b1;
    run_to(43); SOFT_REQ = 3'b010;
    run_to(46); SOFT_REQ = 3'b000;
    run_to(54); SOFT_REQ = 3'b100;
    run_to(55); SOFT_REQ = 3'b000;
    run_to(58); SOFT_REQ = 3'b100;
    run_to(59); SOFT_REQ = 3'b000;
    run_to(83);
    check("sb_drained", 32'(sb.size()), 32'd0);

    #3 RST_X = 1'b0;
    #1 check_reset_now("async2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
